// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED
// "set LEDs" or 0xFF "reset") to a keyboard over the shared open-drain PS/2
// lines. The device generates the clock; the host only pulls lines low.
//
// Ports
//   clk          system clock
//   clr          asynchronous active-high reset
//   ps2_clk      resolved PS/2 clock line (asynchronous to clk)
//   ps2_data     resolved PS/2 data line (asynchronous to clk)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   tx_data      command byte, sampled on accept
//   tx_valid     request to send tx_data
//   tx_ready     high only while idle; accept = tx_valid & tx_ready
//   busy         high whenever a transfer is in progress (receiver ignores bus)
//   done         one-cycle pulse at the end of a transfer
//   ack_err      one-cycle pulse together with done when the device did not ack
//   timeout      one-cycle pulse when a transfer is aborted for lack of clocks
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    // One counter serves both the inhibit interval and the transfer timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      clk_sync_q;
    logic [2:0]      data_sync_q;
    logic [9:0]      shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            timeout_q, timeout_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    logic            fall_s;
    logic            accept_s;
    logic            timing_s;

    // Bit [0] is the newest sample; a fall is "old high, newer low".
    assign fall_s   = clk_sync_q[2] & ~clk_sync_q[1];
    assign accept_s = tx_valid & ready_q;
    // States in which the device is expected to be clocking.
    assign timing_s = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

    // Three-flop synchronizers for the asynchronous PS/2 lines.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    // Next-state, datapath and output-enable decode.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (accept_s) begin
                    state_d   = ST_INHIBIT;
                    // Frame: stop(1), odd parity, data byte (sent LSB first).
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    nack_d    = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                data_oe_d = 1'b0;
                if (cnt_q == INH_LAST) begin
                    state_d   = ST_REQ;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_REQ: begin
                // Start bit stays driven while the clock is released.
                data_oe_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (fall_s) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_ACK: begin
                data_oe_d = 1'b0;
                cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (fall_s) begin
                    nack_d  = data_sync_q[2];
                    state_d = ST_WAIT_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (clk_sync_q[2] && data_sync_q[2]) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    ack_err_d = nack_q;
                end else begin
                    state_d   = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        // Abort takes priority over any completion in the same cycle.
        if (timing_s && (cnt_q == TO_LAST)) begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            timeout_d = 1'b1;
        end else begin
            timeout_d = 1'b0;
        end

        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            shift_q   <= 10'd0;
            bit_cnt_q <= 4'd0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 600;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       dev_clk, dev_data;
    logic       ps2_clk, ps2_data;
    logic       clk_oe, data_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, done, ack_err, timeout;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device.
    assign ps2_clk  = dev_clk  & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    // Pulse / cycle monitor.
    int   cyc = 0, cnt_oe = 0, n_done = 0, n_to = 0, rel_cyc = 0, to_cyc = 0;
    logic last_err = 1'b0, prev_oe = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clk_oe) cnt_oe <= cnt_oe + 1;
        if (done) begin
            n_done   <= n_done + 1;
            last_err <= ack_err;
        end
        if (timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (prev_oe && !clk_oe) rel_cyc <= cyc;
        prev_oe <= clk_oe;
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         par;
        bit         err;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Keyboard model: waits for the request-to-send, clocks the frame and
    // records bit[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_xfer(input bit do_ack, input int stop_after, input bit hold,
                            output logic [10:0] bits);
        int w;
        bits = 11'h7FF;
        w = 0;
        while (!(clk_oe == 1'b0 && ps2_data == 1'b0) && w < INH + 50) begin
            step(1);
            w++;
        end
        if (w >= INH + 50) begin
            checks++;
            errors++;
            $display("FAIL req_seen: no request within %0d cycles", w);
            return;
        end
        step(4);
        bits[0] = ps2_data;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (hold) tx_data = tx_data ^ 8'h5A;
            if (hold && k == 10) tx_valid = 1'b0;
            if (k == stop_after) return;
            step(HALF);
            dev_clk = 1'b1;
            if (k <= 10) bits[k] = ps2_data;
            if (k == 11) dev_data = 1'b1;
            else if (k == 10 && do_ack) dev_data = 1'b0;
            step(HALF);
        end
    endtask

    task automatic do_xfer(input logic [7:0] data, input bit do_ack, input bit hold,
                           input bit exp_par, input bit exp_err, input string tag);
        int oe0, d0, t0, w;
        logic [10:0] bits;
        step(1);
        oe0 = cnt_oe; d0 = n_done; t0 = n_to;
        tx_data  = data;
        tx_valid = 1'b1;
        step(1);
        if (!hold) tx_valid = 1'b0;
        chk({tag, " ready_low"}, tx_ready, 1'b0);
        chk({tag, " busy_high"}, busy, 1'b1);
        dev_xfer(do_ack, 0, hold, bits);
        w = 0;
        while (n_done == d0 && w < 200) begin
            step(1);
            w++;
        end
        step(2);
        chk({tag, " start"},  bits[0], 1'b0);
        chk({tag, " byte"},   bits[8:1], data);
        chk({tag, " parity"}, bits[9], exp_par);
        chk({tag, " stop"},   bits[10], 1'b1);
        chk({tag, " done_n"}, n_done - d0, 1);
        chk({tag, " ack_err"}, last_err, exp_err);
        chk({tag, " no_to"},  n_to - t0, 0);
        chk({tag, " clk_oe_cycles"}, cnt_oe - oe0, INH + 1);
        chk({tag, " ready_after"}, tx_ready, 1'b1);
        chk({tag, " busy_after"},  busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, w;
        logic [10:0] bits;

        vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, err: 1'b0};
        vecs[1] = '{data: 8'h07, ack: 1'b1, par: 1'b0, err: 1'b0};
        vecs[2] = '{data: 8'h00, ack: 1'b1, par: 1'b1, err: 1'b0};
        vecs[3] = '{data: 8'hA5, ack: 1'b1, par: 1'b1, err: 1'b0};
        vecs[4] = '{data: 8'h3C, ack: 1'b0, par: 1'b1, err: 1'b1};

        clr = 1'b1; dev_clk = 1'b1; dev_data = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        step(2);
        chk("rst clk_oe",  clk_oe, 1'b0);
        chk("rst data_oe", data_oe, 1'b0);
        chk("rst ready",   tx_ready, 1'b1);
        chk("rst busy",    busy, 1'b0);
        chk("rst done",    done, 1'b0);
        chk("rst ack_err", ack_err, 1'b0);
        chk("rst timeout", timeout, 1'b0);
        clr = 1'b0;
        step(3);

        for (int i = 0; i < 5; i++)
            do_xfer(vecs[i].data, vecs[i].ack, 1'b0, vecs[i].par, vecs[i].err, $sformatf("vec%0d", i));

        // tx_valid held with changing tx_data during the transfer.
        do_xfer(8'h96, 1'b1, 1'b1, 1'b1, 1'b0, "hold");
        d0 = n_done;
        step(30);
        chk("hold no_second_done", n_done - d0, 0);
        chk("hold idle", busy, 1'b0);

        // Device never clocks: timeout.
        d0 = n_done; t0 = n_to;
        tx_data = 8'h55; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        w = 0;
        while (n_to == t0 && w < INH + TO + 100) begin
            step(1);
            w++;
        end
        step(1);
        chk("to pulses", n_to - t0, 1);
        chk("to latency", to_cyc - rel_cyc, TO);
        chk("to clk_oe", clk_oe, 1'b0);
        chk("to data_oe", data_oe, 1'b0);
        chk("to no_done", n_done - d0, 0);
        chk("to ready", tx_ready, 1'b1);

        // Reset in the middle of the frame.
        tx_data = 8'h00; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        dev_xfer(1'b1, 4, 1'b0, bits);
        step(6);
        chk("clr pre data_oe", data_oe, 1'b1);
        chk("clr pre busy", busy, 1'b1);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        chk("clr clk_oe", clk_oe, 1'b0);
        chk("clr data_oe", data_oe, 1'b0);
        chk("clr ready", tx_ready, 1'b1);
        chk("clr busy", busy, 1'b0);
        step(2);
        clr = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
        step(10);
        do_xfer(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "after_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
